control_unit_ldst: RTL and testbench
====================================

# control_unit_ldst

Hardwired Moore control sequencer for the Mini SRC datapath. It drives every datapath control input to fetch an instruction and execute `ld`, `ldi`, `st`, `addi`, `nop` and `halt`. The sequencing matches the team's hand-written T0–T7 benches, so the datapath can run programs from RAM without a testbench FSM. It sits beside `datapath` and reads only the opcode field of IR.

## Interface
Parameters:
- BUS_PC, 5'b10100, BusDataSelect code for PC
- BUS_ZLO, 5'b10011, BusDataSelect code for Zlow
- BUS_MDR, 5'b10101, BusDataSelect code for MDR
- BUS_C, 5'b01100, BusDataSelect code for the sign-extended constant
- BUS_REG, 5'b00000, BusDataSelect code for the select/encode register output
- ALU_ADD, 4'b0011, ALU_op code for ADD

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  synchronous, active-high reset
- run  in  1  start request, sampled only in IDLE
- opcode  in  5  IR[31:27] from the datapath
- incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR  out  1 each  datapath register enables
- ram_read, ram_write, MDR_read  out  1 each  memory controls
- Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel  out  1 each  select/encode and operand controls
- ALU_op  out  4  ALU operation
- BusDataSelect  out  5  bus source
- halted  out  1  high while in HALT
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- instr_count  out  32  retired-instruction count (see Configuration)
- state_dbg  out  4  current state encoding

## Operation
- Moore machine: every output is a pure decode of the state register. Any signal not listed for a state is 0; BusDataSelect defaults to 5'b00000 and ALU_op defaults to 4'b0000.
- States and encodings: IDLE=0, T0=1, T0W=2, T1=3, T1W=4, T2=5, T3=6, T4=7, T5=8, T5W=9, T6=10, T6W=11, T7=12, HALT=13. Codes 14 and 15 are illegal and go to IDLE on the next edge.
- Fetch sequence:
  - IDLE → T0 when run=1, otherwise stay in IDLE.
  - T0: BUS_PC, e_MAR, incPC, e_Z.
  - T0W: no outputs.
  - T1: BUS_ZLO, e_PC, ram_read.
  - T1W: ram_read, MDR_read, e_MDR.
  - T2: BUS_MDR, e_IR.
- T3 decodes opcode:
  - ld 00000, ldi 00001, st 00010: Grb, BAout, BUS_REG, e_Y.
  - addi 01100: Grb, e_Rout, BUS_REG, e_Y.
  - halt 11011: next state HALT, no outputs.
  - nop 11010 and every other code: next state T0, instr_done=1.
- T4 (ld, ldi, st, addi): BUS_C, imm_sel, ALU_ADD, e_Z.
- T5:
  - ldi, addi: BUS_ZLO, Gra, e_Rin, instr_done; next state T0.
  - ld, st: BUS_ZLO, e_MAR; next state T5W.
- T5W: no outputs.
- T6:
  - ld: ram_read.
  - st: Gra, e_Rout, BUS_REG, e_MDR with MDR_read=0.
- T6W:
  - ld: ram_read, MDR_read, e_MDR.
  - st: ram_write.
- T7:
  - ld: BUS_MDR, Gra, e_Rin, instr_done.
  - st: instr_done only.
  - Next state T0 in both cases.
- The decoded opcode class is latched into a 2-bit register in T3, so later states do not depend on opcode staying stable.
- HALT: halted=1, no other outputs; left only by clear.

## Timing
- One state per clock cycle; outputs are valid for the whole cycle in which the state is occupied.
- Instruction lengths, counted from T0 to the instr_done state inclusive: ld 12, st 12, ldi 8, addi 8, nop/unknown 6 cycles.
- The next T0 follows the instr_done cycle directly; run is not re-sampled between instructions.
- clear=1 at a rising edge, in any state including mid-instruction or HALT: the next state is IDLE, all outputs are 0 in the following cycle, and the latched opcode class is zeroed.
- clear has priority over run.
- Reset values: every output is 0 and state_dbg=0.

## Configuration
- CU_INSTR_COUNT_EN defined:
  - instr_count is a 32-bit register, cleared by clear, incremented on each edge that leaves a state with instr_done=1.
  - It wraps 0xFFFFFFFF→0.
  - halt does not increment it.
- CU_INSTR_COUNT_EN undefined: instr_count is tied to 32'd0 and no counter flops exist.

## Test plan
- ld R4,0x54 with RAM[0x54]=0x97:
  - clear 1 cycle, run=1 → R4=0x97 after 12 cycles.
  - PC=1, instr_done pulses once, instr_count=1 (macro on).
- ldi R3,0x54(R2) with R2=0x78: R3=0xCC after 8 cycles.
- st 0x87(R1),R1 with R1=0x67:
  - RAM[0xEE]=0x67 after 12 cycles.
  - ram_write is high in exactly one cycle (T6W).
- addi R5,R5,-5 with R5=0x10: R5=0x0B, no ram_read outside fetch.
- Program nop, unknown opcode 10101, halt:
  - 6 + 6 + T0..T3 cycles, then halted=1 held.
  - instr_count=2; run toggling has no effect.
- clear asserted in T5W of ld:
  - Next cycle IDLE, all outputs 0, destination register unchanged.
  - run=1 restarts the fetch from the current PC.

Source files
------------

// File: rtl/control_unit_ldst.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch plus ld/ldi/st/addi/nop/halt.
// Optional retired-instruction counter enabled by defining CU_INSTR_COUNT_EN.
module control_unit_ldst #(
    parameter logic [4:0] BUS_PC  = 5'b10100,
    parameter logic [4:0] BUS_ZLO = 5'b10011,
    parameter logic [4:0] BUS_MDR = 5'b10101,
    parameter logic [4:0] BUS_C   = 5'b01100,
    parameter logic [4:0] BUS_REG = 5'b00000,
    parameter logic [3:0] ALU_ADD = 4'b0011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [4:0]  opcode,
    output logic        incPC,
    output logic        e_PC,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_MDR,
    output logic        e_MAR,
    output logic        ram_read,
    output logic        ram_write,
    output logic        MDR_read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        e_Rin,
    output logic        e_Rout,
    output logic        BAout,
    output logic        imm_sel,
    output logic [3:0]  ALU_op,
    output logic [4:0]  BusDataSelect,
    output logic        halted,
    output logic        instr_done,
    output logic [31:0] instr_count,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,  T0  = 4'd1,  T0W = 4'd2,  T1   = 4'd3,
        T1W  = 4'd4,  T2  = 4'd5,  T3  = 4'd6,  T4   = 4'd7,
        T5   = 4'd8,  T5W = 4'd9,  T6  = 4'd10, T6W  = 4'd11,
        T7   = 4'd12, HALT = 4'd13
    } state_t;

    typedef enum logic [1:0] {C_LD, C_LDI, C_ST, C_ADDI} cls_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t state, next_state;
    cls_t   cls;

    function automatic cls_t decode_class(input logic [4:0] op);
        case (op)
            OP_LDI:  return C_LDI;
            OP_ST:   return C_ST;
            OP_ADDI: return C_ADDI;
            default: return C_LD;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            cls   <= C_LD;
        end else begin
            state <= next_state;
            if (state == T3)
                cls <= decode_class(opcode);
        end
    end

    always_comb begin
        next_state    = state;
        incPC         = 1'b0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_MDR         = 1'b0;
        e_MAR         = 1'b0;
        ram_read      = 1'b0;
        ram_write     = 1'b0;
        MDR_read      = 1'b0;
        Gra           = 1'b0;
        Grb           = 1'b0;
        Grc           = 1'b0;
        e_Rin         = 1'b0;
        e_Rout        = 1'b0;
        BAout         = 1'b0;
        imm_sel       = 1'b0;
        ALU_op        = 4'b0000;
        BusDataSelect = 5'b00000;
        halted        = 1'b0;
        instr_done    = 1'b0;
        case (state)
            IDLE: if (run) next_state = T0;
            T0: begin
                BusDataSelect = BUS_PC;
                e_MAR = 1'b1;
                incPC = 1'b1;
                e_Z   = 1'b1;
                next_state = T0W;
            end
            T0W: next_state = T1;
            T1: begin
                BusDataSelect = BUS_ZLO;
                e_PC     = 1'b1;
                ram_read = 1'b1;
                next_state = T1W;
            end
            T1W: begin
                ram_read = 1'b1;
                MDR_read = 1'b1;
                e_MDR    = 1'b1;
                next_state = T2;
            end
            T2: begin
                BusDataSelect = BUS_MDR;
                e_IR = 1'b1;
                next_state = T3;
            end
            // Only state that looks at the live opcode; later states use the latched class.
            T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        Grb = 1'b1;
                        BAout = 1'b1;
                        BusDataSelect = BUS_REG;
                        e_Y = 1'b1;
                        next_state = T4;
                    end
                    OP_ADDI: begin
                        Grb = 1'b1;
                        e_Rout = 1'b1;
                        BusDataSelect = BUS_REG;
                        e_Y = 1'b1;
                        next_state = T4;
                    end
                    OP_HALT: next_state = HALT;
                    default: begin
                        instr_done = 1'b1;
                        next_state = T0;
                    end
                endcase
            end
            T4: begin
                BusDataSelect = BUS_C;
                imm_sel = 1'b1;
                ALU_op  = ALU_ADD;
                e_Z     = 1'b1;
                next_state = T5;
            end
            T5: begin
                BusDataSelect = BUS_ZLO;
                if (cls == C_LDI || cls == C_ADDI) begin
                    Gra = 1'b1;
                    e_Rin = 1'b1;
                    instr_done = 1'b1;
                    next_state = T0;
                end else begin
                    e_MAR = 1'b1;
                    next_state = T5W;
                end
            end
            T5W: next_state = T6;
            T6: begin
                if (cls == C_ST) begin
                    Gra = 1'b1;
                    e_Rout = 1'b1;
                    BusDataSelect = BUS_REG;
                    e_MDR = 1'b1;
                end else begin
                    ram_read = 1'b1;
                end
                next_state = T6W;
            end
            T6W: begin
                if (cls == C_ST) begin
                    ram_write = 1'b1;
                end else begin
                    ram_read = 1'b1;
                    MDR_read = 1'b1;
                    e_MDR    = 1'b1;
                end
                next_state = T7;
            end
            T7: begin
                if (cls != C_ST) begin
                    BusDataSelect = BUS_MDR;
                    Gra   = 1'b1;
                    e_Rin = 1'b1;
                end
                instr_done = 1'b1;
                next_state = T0;
            end
            HALT: halted = 1'b1;
            default: next_state = IDLE;
        endcase
    end

    assign state_dbg = state;

`ifdef CU_INSTR_COUNT_EN
    logic [31:0] count;

    always_ff @(posedge clock) begin
        if (clear)
            count <= 32'd0;
        else if (instr_done)
            count <= count + 32'd1;
    end

    assign instr_count = count;
`else
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_control_unit_ldst.sv
// Self-checking bench for control_unit_ldst: directed per-instruction table, corner
// sequences and a random program compared against a per-cycle expected-output trace.
module tb_control_unit_ldst;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic [4:0]  opcode = 5'b0;
    logic        incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR;
    logic        ram_read, ram_write, MDR_read;
    logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic        halted, instr_done;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    control_unit_ldst dut (
        .clock(clock), .clear(clear), .run(run), .opcode(opcode),
        .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z),
        .e_MDR(e_MDR), .e_MAR(e_MAR), .ram_read(ram_read), .ram_write(ram_write),
        .MDR_read(MDR_read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin),
        .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel), .ALU_op(ALU_op),
        .BusDataSelect(BusDataSelect), .halted(halted), .instr_done(instr_done),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_NOP = 5'b11010, OP_HALT = 5'b11011;
    localparam logic [4:0] OP_UNK = 5'b10101;

    // Packed view of all control outputs: 17 single bits, ALU_op, bus, halted, instr_done.
    localparam logic [27:0] INCPC = 28'd1 << 27, EPC = 28'd1 << 26, EIR = 28'd1 << 25;
    localparam logic [27:0] EY = 28'd1 << 24, EZ = 28'd1 << 23, EMDR = 28'd1 << 22;
    localparam logic [27:0] EMAR = 28'd1 << 21, RR = 28'd1 << 20, RW = 28'd1 << 19;
    localparam logic [27:0] MDRR = 28'd1 << 18, GRA = 28'd1 << 17, GRB = 28'd1 << 16;
    localparam logic [27:0] EROUT = 28'd1 << 13, ERIN = 28'd1 << 14, BAOUT = 28'd1 << 12;
    localparam logic [27:0] IMM = 28'd1 << 11, HLT = 28'd1 << 1, DONE = 28'd1;
    localparam logic [27:0] B_PC = {21'd0, 5'b10100, 2'd0}, B_ZLO = {21'd0, 5'b10011, 2'd0};
    localparam logic [27:0] B_MDR = {21'd0, 5'b10101, 2'd0}, B_C = {21'd0, 5'b01100, 2'd0};
    localparam logic [27:0] B_REG = 28'd0, A_ADD = {17'd0, 4'b0011, 7'd0};

    typedef struct {
        logic [4:0]  op;
        logic [27:0] v;
    } step_t;

    typedef struct {
        logic [4:0] op;
        int         len;
        int         reads;
        int         writes;
        int         rins;
    } vec_t;

    step_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [27:0] outs();
        return {incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, ram_read, ram_write, MDR_read,
                Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, ALU_op, BusDataSelect,
                halted, instr_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] op, input logic [27:0] v);
        q.push_back('{op, v});
    endtask

    // Expected per-cycle control trace of one instruction, written from the instruction's
    // micro-step list; the opcode bus carries junk once decode is past.
    task automatic gen_instr(input logic [4:0] op);
        add(op, B_PC | EMAR | INCPC | EZ);
        add(op, 28'd0);
        add(op, B_ZLO | EPC | RR);
        add(op, RR | MDRR | EMDR);
        add(op, B_MDR | EIR);
        if (op == OP_HALT) begin
            add(op, 28'd0);
            return;
        end
        if (op == OP_LD || op == OP_LDI || op == OP_ST)
            add(op, GRB | BAOUT | B_REG | EY);
        else if (op == OP_ADDI)
            add(op, GRB | EROUT | B_REG | EY);
        else begin
            add(op, DONE);
            return;
        end
        add(5'($urandom), B_C | IMM | A_ADD | EZ);
        if (op == OP_LDI || op == OP_ADDI) begin
            add(5'($urandom), B_ZLO | GRA | ERIN | DONE);
            return;
        end
        add(5'($urandom), B_ZLO | EMAR);
        add(5'($urandom), 28'd0);
        if (op == OP_LD) begin
            add(5'($urandom), RR);
            add(5'($urandom), RR | MDRR | EMDR);
            add(5'($urandom), B_MDR | GRA | ERIN | DONE);
        end else begin
            add(5'($urandom), GRA | EROUT | B_REG | EMDR);
            add(5'($urandom), RW);
            add(5'($urandom), DONE);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        run = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;
    endtask

    // Plays the queued trace cycle by cycle, toggling run at random along the way.
    task automatic play(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            opcode = q[i].op;
            #1;
            chk({tag, "_outs"}, {4'd0, outs()}, {4'd0, q[i].v});
            run = 1'($urandom);
            @(posedge clock);
            #1;
        end
        run = 1'b0;
    endtask

    vec_t tbl[6];
    int   len, reads, writes, rins, want_cnt;

    initial begin
        tbl[0] = '{OP_LD,   12, 4, 0, 1};
        tbl[1] = '{OP_ST,   12, 2, 1, 0};
        tbl[2] = '{OP_LDI,   8, 2, 0, 1};
        tbl[3] = '{OP_ADDI,  8, 2, 0, 1};
        tbl[4] = '{OP_NOP,   6, 2, 0, 0};
        tbl[5] = '{OP_UNK,   6, 2, 0, 0};

        do_clear();
        chk("reset_outs", {4'd0, outs()}, 32'd0);
        chk("reset_state", {28'd0, state_dbg}, 32'd0);
        chk("reset_count", instr_count, 32'd0);
        @(posedge clock);
        #1;
        chk("idle_hold", {28'd0, state_dbg}, 32'd0);

        for (int t = 0; t < 6; t++) begin
            do_clear();
            opcode = tbl[t].op;
            start();
            len = 0; reads = 0; writes = 0; rins = 0;
            for (int c = 0; c < 20; c++) begin
                len++;
                reads  += int'(ram_read);
                writes += int'(ram_write);
                rins   += int'(e_Rin);
                if (instr_done) break;
                @(posedge clock);
                #1;
            end
            chk($sformatf("len_%0d", t), len, tbl[t].len);
            chk($sformatf("reads_%0d", t), reads, tbl[t].reads);
            chk($sformatf("writes_%0d", t), writes, tbl[t].writes);
            chk($sformatf("rins_%0d", t), rins, tbl[t].rins);
            @(posedge clock);
            #1;
            chk($sformatf("next_t0_%0d", t), {28'd0, state_dbg}, 32'd1);
`ifdef CU_INSTR_COUNT_EN
            chk($sformatf("count_%0d", t), instr_count, 32'd1);
`else
            chk($sformatf("count_%0d", t), instr_count, 32'd0);
`endif
        end

        // clear in T5W of ld aborts back to IDLE; run then restarts the fetch
        do_clear();
        opcode = OP_LD;
        start();
        repeat (8) begin
            @(posedge clock);
            #1;
        end
        chk("t5w_state", {28'd0, state_dbg}, 32'd9);
        clear = 1'b1;
        run = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        run = 1'b0;
        chk("abort_outs", {4'd0, outs()}, 32'd0);
        chk("abort_state", {28'd0, state_dbg}, 32'd0);
        chk("abort_count", instr_count, 32'd0);
        start();
        chk("restart_state", {28'd0, state_dbg}, 32'd1);
        chk("restart_outs", {4'd0, outs()}, {4'd0, B_PC | EMAR | INCPC | EZ});

        // nop, unknown, halt: HALT is sticky regardless of run
        q.delete();
        gen_instr(OP_NOP);
        gen_instr(OP_UNK);
        gen_instr(OP_HALT);
        repeat (6) add(5'($urandom), HLT);
        do_clear();
        start();
        play("halt_prog");
        chk("halt_state", {28'd0, state_dbg}, 32'd13);
`ifdef CU_INSTR_COUNT_EN
        chk("halt_count", instr_count, 32'd2);
`else
        chk("halt_count", instr_count, 32'd0);
`endif
        do_clear();
        chk("halt_cleared", {28'd0, state_dbg}, 32'd0);

        // random program terminated by halt
        q.delete();
        want_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            logic [4:0] op;
            case ($urandom_range(0, 6))
                0: op = OP_LD;
                1: op = OP_LDI;
                2: op = OP_ST;
                3: op = OP_ADDI;
                4: op = OP_NOP;
                default: begin
                    op = 5'($urandom);
                    if (op == OP_HALT) op = OP_NOP;
                end
            endcase
            gen_instr(op);
            want_cnt++;
        end
        gen_instr(OP_HALT);
        repeat (4) add(5'($urandom), HLT);
        do_clear();
        start();
        play("rand");
`ifdef CU_INSTR_COUNT_EN
        chk("rand_count", instr_count, 32'(want_cnt));
`else
        chk("rand_count", instr_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
